// File: rtl/gf180mcu_fd_sc_mcu7t5v0__drive_pkg.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__drive_pkg.sv - shared types and helpers for the inverter drive ramp sequencer
// Contents: ramp FSM state enum, request clamp function, thermometer decode function.
package gf180mcu_fd_sc_mcu7t5v0__drive_pkg;

    // Widest supported bank is 15 fingers; helpers work one bit wider than the
    // largest design so callers can always slice off a non-empty spare range.
    localparam int MAX_N  = 16;
    localparam int MAX_CW = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2
    } drive_state_e;

    function automatic logic [MAX_CW-1:0] clamp_code(input logic [MAX_CW-1:0] code, input int n);
        if (int'(code) > n) begin
            return MAX_CW'(n);
        end
        return code;
    endfunction

    // Bit i set when finger i is enabled: below the level and inside the bank.
    function automatic logic [MAX_N-1:0] therm(input logic [MAX_CW-1:0] level, input int n);
        logic [MAX_N-1:0] t;
        for (int i = 0; i < MAX_N; i++) begin
            t[i] = (i < int'(level)) && (i < n);
        end
        return t;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__drive_step_tmr.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__drive_step_tmr.sv - reloadable step-interval down-counter
// Ports: CLK/RN clock and async active-low reset; load_i reloads STEP_CYCLES-1;
//        run_i enables counting; hold_i freezes the count; tick_o marks a step edge.
module gf180mcu_fd_sc_mcu7t5v0__drive_step_tmr #(
    parameter int STEP_CYCLES = 4
) (
    input  logic CLK,
    input  logic RN,
    input  logic load_i,
    input  logic run_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(STEP_CYCLES - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // A step happens on the edge where a running, unheld counter sits at zero.
    assign tick_o = run_i && !hold_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (run_i && !hold_i) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - TW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__inv_drive_seq.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__inv_drive_seq.sv - drive-strength ramp sequencer for a bank of inverter fingers
// Ports: CLK/RN clock and async active-low reset; VDD/VSS supplies; REQ/CODE request
//        and finger count; HOLD freezes the ramp; ACK target-reached pulse; BUSY ramping;
//        LEVEL enabled finger count; EN thermometer finger enables.
module gf180mcu_fd_sc_mcu7t5v0__inv_drive_seq
    import gf180mcu_fd_sc_mcu7t5v0__drive_pkg::*;
#(
    parameter  int N_FINGERS   = 8,
    parameter  int STEP_CYCLES = 4,
    localparam int CW          = $clog2(N_FINGERS + 1)
) (
    input  logic                 CLK,
    input  logic                 RN,
    inout  wire                  VDD,
    inout  wire                  VSS,
    input  logic                 REQ,
    input  logic [CW-1:0]        CODE,
    input  logic                 HOLD,
    output logic                 ACK,
    output logic                 BUSY,
    output logic [CW-1:0]        LEVEL,
    output logic [N_FINGERS-1:0] EN
);

    drive_state_e         state_q;
    logic [CW-1:0]        level_q;
    logic [CW-1:0]        level_d;
    logic [CW-1:0]        target_q;
    logic [CW-1:0]        code_clamped;
    logic [N_FINGERS-1:0] en_q;
    logic                 ack_q;
    logic                 busy_q;
    logic                 tick;
    logic                 accept;

    logic [MAX_CW-1:0]    code_ext;
    logic [MAX_CW-1:0]    clamp_full;
    logic [MAX_CW-1:0]    level_ext;
    logic [MAX_N-1:0]     therm_full;

    // Spare helper bits above this bank's width are always zero; the supplies
    // are pass-through pins with no logic behind them.
    wire unused_spare = ^{clamp_full[MAX_CW-1:CW], therm_full[MAX_N-1:N_FINGERS], VDD, VSS};

    assign accept = (state_q == IDLE) && REQ;

    always_comb begin
        code_ext           = '0;
        code_ext[CW-1:0]   = CODE;
        clamp_full         = clamp_code(code_ext, N_FINGERS);
        code_clamped       = clamp_full[CW-1:0];
    end

    gf180mcu_fd_sc_mcu7t5v0__drive_step_tmr #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_tmr (
        .CLK    (CLK),
        .RN     (RN),
        .load_i (accept),
        .run_i  (state_q != IDLE),
        .hold_i (HOLD),
        .tick_o (tick)
    );

    // Next level moves by one finger per tick; the enables are decoded from it
    // so EN is registered on the same edge as LEVEL.
    always_comb begin
        level_d = level_q;
        if (tick) begin
            if (state_q == RAMP_UP) begin
                level_d = level_q + CW'(1);
            end else if (state_q == RAMP_DN) begin
                level_d = level_q - CW'(1);
            end
        end
        level_ext          = '0;
        level_ext[CW-1:0]  = level_d;
        therm_full         = therm(level_ext, N_FINGERS);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q  <= IDLE;
            level_q  <= '0;
            target_q <= '0;
            en_q     <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            en_q    <= therm_full[N_FINGERS-1:0];
            ack_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (REQ) begin
                        target_q <= code_clamped;
                        if (code_clamped > level_q) begin
                            state_q <= RAMP_UP;
                            busy_q  <= 1'b1;
                        end else if (code_clamped < level_q) begin
                            state_q <= RAMP_DN;
                            busy_q  <= 1'b1;
                        end else begin
                            ack_q <= 1'b1;
                        end
                    end
                end
                RAMP_UP, RAMP_DN: begin
                    if (tick && (level_d == target_q)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ack_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ACK   = ack_q;
    assign BUSY  = busy_q;
    assign LEVEL = level_q;
    assign EN    = en_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__inv_drive_seq.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__inv_drive_seq.sv - self-checking bench for the inverter drive ramp sequencer
module tb_gf180mcu_fd_sc_mcu7t5v0__inv_drive_seq;

    localparam int N    = 8;
    localparam int STEP = 4;
    localparam int CW   = 4;

    logic          CLK  = 1'b0;
    logic          RN   = 1'b0;
    logic          REQ  = 1'b0;
    logic          HOLD = 1'b0;
    logic [CW-1:0] CODE = '0;
    wire           VDD  = 1'b1;
    wire           VSS  = 1'b0;
    logic          ACK;
    logic          BUSY;
    logic [CW-1:0] LEVEL;
    logic [N-1:0]  EN;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: fingers enabled, ramp destination, direction and edges left until next step.
    int m_level, m_target, m_busy, m_ack, m_dir, m_wait;

    typedef struct {
        int req;
        int code;
        int hold;
        int n;
        int lvl;
        int busy;
        int ack;
    } vec_t;

    vec_t tbl[19];

    gf180mcu_fd_sc_mcu7t5v0__inv_drive_seq #(
        .N_FINGERS   (N),
        .STEP_CYCLES (STEP)
    ) dut (
        .CLK   (CLK),
        .RN    (RN),
        .VDD   (VDD),
        .VSS   (VSS),
        .REQ   (REQ),
        .CODE  (CODE),
        .HOLD  (HOLD),
        .ACK   (ACK),
        .BUSY  (BUSY),
        .LEVEL (LEVEL),
        .EN    (EN)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(int r, int c, int h, int n, int l, int b, int a);
        vec_t v;
        v.req = r; v.code = c; v.hold = h; v.n = n; v.lvl = l; v.busy = b; v.ack = a;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_target = 0; m_busy = 0; m_ack = 0; m_dir = 0; m_wait = 0;
    endtask

    task automatic model_edge(input bit req, input int code, input bit hold);
        m_ack = 0;
        if (m_busy == 0) begin
            if (req) begin
                m_target = (code > N) ? N : code;
                if (m_target == m_level) begin
                    m_ack = 1;
                end else begin
                    m_busy = 1;
                    m_dir  = (m_target > m_level) ? 1 : -1;
                    m_wait = STEP;
                end
            end
        end else if (!hold) begin
            m_wait--;
            if (m_wait == 0) begin
                m_level += m_dir;
                m_wait   = STEP;
                if (m_level == m_target) begin
                    m_busy = 0;
                    m_ack  = 1;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 ns later.
    task automatic cyc(input bit req, input int code, input bit hold);
        REQ  = req;
        CODE = code[CW-1:0];
        HOLD = hold;
        @(posedge CLK);
        model_edge(req, code, hold);
        #1;
        check("level", int'(LEVEL), m_level);
        check("en",    int'(EN),    (1 << m_level) - 1);
        check("busy",  int'(BUSY),  m_busy);
        check("ack",   int'(ACK),   m_ack);
    endtask

    initial begin
        // Ramp up to 3, clamp 12 -> 8, full ramp down to 0, equal-target request.
        tbl[0]  = mk(1, 3,  0, 1,  0, 1, 0);
        tbl[1]  = mk(0, 3,  0, 3,  0, 1, 0);
        tbl[2]  = mk(0, 3,  0, 1,  1, 1, 0);
        tbl[3]  = mk(0, 3,  0, 4,  2, 1, 0);
        tbl[4]  = mk(0, 3,  0, 3,  2, 1, 0);
        tbl[5]  = mk(0, 3,  0, 1,  3, 0, 1);
        tbl[6]  = mk(0, 3,  0, 1,  3, 0, 0);
        tbl[7]  = mk(1, 12, 0, 1,  3, 1, 0);
        tbl[8]  = mk(0, 12, 0, 19, 7, 1, 0);
        tbl[9]  = mk(0, 12, 0, 1,  8, 0, 1);
        tbl[10] = mk(1, 0,  0, 1,  8, 1, 0);
        tbl[11] = mk(0, 0,  0, 31, 1, 1, 0);
        tbl[12] = mk(0, 0,  0, 1,  0, 0, 1);
        tbl[13] = mk(0, 0,  0, 1,  0, 0, 0);
        tbl[14] = mk(1, 5,  0, 1,  0, 1, 0);
        tbl[15] = mk(0, 5,  0, 19, 4, 1, 0);
        tbl[16] = mk(0, 5,  0, 1,  5, 0, 1);
        tbl[17] = mk(1, 5,  0, 1,  5, 0, 1);
        tbl[18] = mk(0, 5,  0, 1,  5, 0, 0);

        repeat (2) @(posedge CLK);
        #1;
        check("rst_level", int'(LEVEL), 0);
        check("rst_en",    int'(EN),    0);
        check("rst_busy",  int'(BUSY),  0);
        check("rst_ack",   int'(ACK),   0);
        RN = 1'b1;
        model_reset();

        for (int i = 0; i < 19; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                cyc(tbl[i].req != 0, tbl[i].code, tbl[i].hold != 0);
            end
            check("tbl_level", int'(LEVEL), tbl[i].lvl);
            check("tbl_en",    int'(EN),    (1 << tbl[i].lvl) - 1);
            check("tbl_busy",  int'(BUSY),  tbl[i].busy);
            check("tbl_ack",   int'(ACK),   tbl[i].ack);
        end

        // HOLD for edges 2..7 during a 0 -> 2 ramp.
        RN = 1'b0;
        #2;
        RN = 1'b1;
        model_reset();
        cyc(1'b1, 2, 1'b0);
        for (int e = 1; e <= 14; e++) begin
            cyc(1'b0, 2, (e >= 2) && (e <= 7));
            if (e == 9)  check("hold_e9_level",  int'(LEVEL), 0);
            if (e == 10) check("hold_e10_level", int'(LEVEL), 1);
            if (e == 13) check("hold_e13_level", int'(LEVEL), 1);
            if (e == 14) begin
                check("hold_e14_level", int'(LEVEL), 2);
                check("hold_e14_ack",   int'(ACK),   1);
            end
        end

        // Request while busy is ignored; REQ held through ACK starts a new ramp.
        cyc(1'b1, 6, 1'b0);
        for (int e = 1; e <= 16; e++) begin
            cyc(e >= 5, (e >= 5) ? 1 : 6, 1'b0);
        end
        check("busyreq_level", int'(LEVEL), 6);
        check("busyreq_ack",   int'(ACK),   1);
        cyc(1'b1, 1, 1'b0);
        check("b2b_busy",  int'(BUSY),  1);
        check("b2b_ack",   int'(ACK),   0);
        check("b2b_level", int'(LEVEL), 6);
        for (int e = 18; e <= 37; e++) begin
            cyc(1'b0, 1, 1'b0);
        end
        check("b2b_end_level", int'(LEVEL), 1);
        check("b2b_end_ack",   int'(ACK),   1);

        // Asynchronous reset between edges at LEVEL=4.
        cyc(1'b1, 8, 1'b0);
        for (int e = 1; e <= 12; e++) begin
            cyc(1'b0, 8, 1'b0);
        end
        check("arst_pre_level", int'(LEVEL), 4);
        #2;
        RN = 1'b0;
        #1;
        check("arst_level", int'(LEVEL), 0);
        check("arst_en",    int'(EN),    0);
        check("arst_busy",  int'(BUSY),  0);
        check("arst_ack",   int'(ACK),   0);
        model_reset();
        #2;
        RN = 1'b1;
        cyc(1'b0, 0, 1'b0);
        cyc(1'b1, 2, 1'b0);
        check("arst_new_busy", int'(BUSY), 1);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
